jtag_host: RTL and testbench
============================

JTAG_HOST -- requirements
Module: jtag_host

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2, clk cycles per TCK half-period (legal 1..255).
REQ-002 SHALL provide parameter MAX_LEN, default 32, maximum scan length in bits.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  host can accept a command.
REQ-007 SHALL have port cmd_type  input  2  0=TLR, 1=IR scan, 2=DR scan, 3=idle clocks.
REQ-008 SHALL have port cmd_len  input  6  scan bit count or idle TCK count.
REQ-009 SHALL have port cmd_data  input  MAX_LEN  TDI scan data, LSB shifted first.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle command-complete pulse.
REQ-011 SHALL have port rsp_data  output  MAX_LEN  captured TDO bits, right-aligned.
REQ-012 SHALL have port busy  output  1  command in progress, equal to !cmd_ready.
REQ-013 SHALL have ports tck, tms, tdi, trst  output  1 each, and tdo  input  1, driving a jtag_test_logic TAP.

Function
REQ-014 SHALL accept a command when cmd_valid && cmd_ready, latching type/len/data; cmd_ready SHALL drop the next cycle.
REQ-015 SHALL generate tck by toggling every CLK_DIV clk cycles only while a sequence runs; tck idles low.
REQ-016 SHALL update tms/tdi on the clk where tck goes low, and sample tdo on the clk where tck goes high.
REQ-017 SHALL be ready only in READY; FSM states: INIT, READY, HEAD, SHIFT, TAIL, RUNIDLE, DONE.
REQ-018 INIT: 5 TCKs with tms=1, then 1 with tms=0 (TAP to Run-Test/Idle), then READY.
REQ-019 TLR command SHALL replay the INIT sequence via HEAD, then DONE.
REQ-020 DR scan HEAD tms sequence SHALL be 1,0,0 (Select-DR, Capture-DR, Shift-DR); IR scan SHALL be 1,1,0,0.
REQ-021 SHIFT SHALL issue N TCKs with tdi=cmd_data[i] on the i-th; tms=0 on all but the last, tms=1 on the last (Exit1).
REQ-022 TAIL SHALL issue tms=1 (Update) then tms=0 (Run-Test/Idle), then DONE.
REQ-023 rsp_data[i] SHALL equal tdo sampled on the i-th shift TCK rising edge; bits >= N SHALL be 0.
REQ-024 Idle command SHALL issue cmd_len TCKs with tms=0, tdi=0 (RUNIDLE).
REQ-025 DONE SHALL assert rsp_valid for exactly one clk (rsp_data=0 for TLR/idle), then READY; cmd_ready SHALL be high on the following clk.
REQ-026 Totals SHALL be: DR N+5 TCKs, IR N+6, TLR 6, idle cmd_len.
REQ-027 cmd_len above MAX_LEN SHALL saturate to MAX_LEN; cmd_len=0 SHALL issue no TCK and go straight to DONE with rsp_data=0.
REQ-028 rsp_data SHALL hold its value until the next DONE; cmd_valid while busy SHALL be ignored.
REQ-029 trst SHALL be 1 while reset is asserted and throughout INIT, and 0 otherwise.
REQ-030 tdi SHALL be 0 outside SHIFT.

Reset
REQ-031 On reset low, immediately: tck=0, tms=1, tdi=0, trst=1, cmd_ready=0, busy=1, rsp_valid=0, rsp_data=0, FSM=INIT, divider cleared.
REQ-032 Reset mid-command SHALL abort without rsp_valid; after release, INIT SHALL run before cmd_ready rises.

Verification
REQ-033 Release reset -> exactly 6 TCKs (tms 1,1,1,1,1,0), trst falls, then cmd_ready=1; with CLK_DIV=2, 24 clks of TCK activity.
REQ-034 Run a DR scan with len=32 and data=0xA5A5_5A5A against the TAP BYPASS-free chain model -> tms trace 1,0,0,0x31,1,1,0; rsp_data equals the model's 32-bit capture; 37 TCKs.
REQ-035 Run an IR scan with len=4 and data=0x5 while tdo is tied to 1 -> tdi trace 1,0,1,0; rsp_data=0x0000000F; 10 TCKs; single rsp_valid pulse.
REQ-036 Send an idle command with len=0 and a DR scan with len=40 -> the idle command produces no TCK and rsp_valid within 2 clks; the scan is treated as 32 bits (37 TCKs).
REQ-037 Assert reset at the 10th shift TCK -> outputs take reset values the same cycle, no rsp_valid, INIT repeats.
REQ-038 Hold cmd_valid continuously with back-to-back commands -> each command accepted exactly once and rsp_valid count equals accepted count.

Source files
------------

// File: rtl/jtag_host.sv
// jtag_host: command-driven JTAG master for a single jtag_test_logic TAP.
//
// Accepts one command at a time (TLR, IR scan, DR scan, idle clocks), walks the TAP
// through the required TMS sequence, shifts cmd_data out on TDI LSB first and returns
// the captured TDO bits right-aligned on rsp_data with a one-cycle rsp_valid pulse.
//
// Ports:
//   clk        in   system clock, all logic on its rising edge
//   reset      in   asynchronous active-low reset
//   cmd_valid  in   command request
//   cmd_ready  out  host can accept a command (only in READY)
//   cmd_type   in   0=TLR, 1=IR scan, 2=DR scan, 3=idle clocks
//   cmd_len    in   scan bit count or idle TCK count (saturates to MAX_LEN)
//   cmd_data   in   TDI scan data, LSB shifted first
//   rsp_valid  out  one-cycle command-complete pulse
//   rsp_data   out  captured TDO bits, right-aligned, held until the next completion
//   busy       out  command in progress (!cmd_ready)
//   tck/tms/tdi/trst out, tdo in: JTAG pins
module jtag_host #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  output logic               trst,
  input  logic               tdo
);

  localparam logic [1:0] CMD_TLR  = 2'd0;
  localparam logic [1:0] CMD_IR   = 2'd1;
  localparam logic [1:0] CMD_IDLE = 2'd3;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] SAT_LEN  = (MAX_LEN < 63) ? 6'(MAX_LEN) : 6'd63;

  typedef enum logic [2:0] {INIT, READY, HEAD, SHIFT, TAIL, RUNIDLE, DONE} state_t;

  state_t             r_state;
  logic [1:0]         r_type;
  logic [5:0]         r_len;
  logic [5:0]         r_cnt;
  logic [7:0]         r_div;
  logic [MAX_LEN-1:0] r_data;
  logic [MAX_LEN-1:0] r_cap;
  logic               r_tck;
  logic               r_tms;
  logic               r_tdi;
  logic               r_trst;
  logic               r_ready;
  logic               r_rsp_valid;
  logic [MAX_LEN-1:0] r_rsp_data;

  logic [5:0]         w_len;
  logic [5:0]         w_last;
  logic [MAX_LEN-1:0] w_aligned;

  // Number of TCKs issued while in a given state.
  function automatic logic [5:0] seq_len(state_t st, logic [1:0] typ, logic [5:0] len);
    case (st)
      INIT:          return 6'd6;
      HEAD: begin
        if (typ == CMD_TLR)     return 6'd6;
        else if (typ == CMD_IR) return 6'd4;
        else                    return 6'd3;
      end
      SHIFT, RUNIDLE: return len;
      TAIL:           return 6'd2;
      default:        return 6'd0;
    endcase
  endfunction

  // TMS value for TCK number cnt within a state.
  function automatic logic seq_tms(state_t st, logic [1:0] typ, logic [5:0] cnt,
                                   logic [5:0] len);
    case (st)
      INIT: return cnt != 6'd5;
      HEAD: begin
        if (typ == CMD_TLR)     return cnt != 6'd5;
        else if (typ == CMD_IR) return cnt < 6'd2;
        else                    return cnt == 6'd0;
      end
      SHIFT:   return cnt == (len - 6'd1);
      TAIL:    return cnt == 6'd0;
      default: return 1'b0;
    endcase
  endfunction

  assign w_len  = (cmd_len > SAT_LEN) ? SAT_LEN : cmd_len;
  assign w_last = seq_len(r_state, r_type, r_len) - 6'd1;
  // Captured bits enter at the MSB, so the first one ends up MAX_LEN-N places up.
  assign w_aligned = r_cap >> (MAX_LEN - 32'(r_len));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= INIT;
      r_type      <= CMD_TLR;
      r_len       <= '0;
      r_cnt       <= '0;
      r_div       <= '0;
      r_data      <= '0;
      r_cap       <= '0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_trst      <= 1'b1;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        READY: begin
          if (cmd_valid) begin
            r_ready <= 1'b0;
            r_type  <= cmd_type;
            r_len   <= w_len;
            r_data  <= cmd_data;
            r_cap   <= '0;
            r_cnt   <= '0;
            r_div   <= '0;
            r_tdi   <= 1'b0;
            if (cmd_type == CMD_TLR) begin
              r_state <= HEAD;
              r_tms   <= 1'b1;
            end else if (w_len == 6'd0) begin
              // Zero-length command: no TCK at all.
              r_state     <= DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '0;
            end else if (cmd_type == CMD_IDLE) begin
              r_state <= RUNIDLE;
              r_tms   <= 1'b0;
            end else begin
              r_state <= HEAD;
              r_tms   <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= READY;
          r_ready <= 1'b1;
        end
        default: begin
          // TCK-issuing states: each TCK is a low half then a high half of CLK_DIV clks.
          if (r_div != DIV_LAST) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div <= '0;
            if (!r_tck) begin
              r_tck <= 1'b1;
              if (r_state == SHIFT) r_cap <= {tdo, r_cap[MAX_LEN-1:1]};
            end else begin
              r_tck <= 1'b0;
              if (r_cnt != w_last) begin
                r_cnt <= r_cnt + 6'd1;
                r_tms <= seq_tms(r_state, r_type, r_cnt + 6'd1, r_len);
                if (r_state == SHIFT) begin
                  r_tdi  <= r_data[0];
                  r_data <= r_data >> 1;
                end
              end else begin
                r_cnt <= '0;
                r_tdi <= 1'b0;
                case (r_state)
                  INIT: begin
                    r_state <= READY;
                    r_ready <= 1'b1;
                    r_trst  <= 1'b0;
                  end
                  HEAD: begin
                    if (r_type == CMD_TLR) begin
                      r_state     <= DONE;
                      r_rsp_valid <= 1'b1;
                      r_rsp_data  <= '0;
                    end else begin
                      r_state <= SHIFT;
                      r_tms   <= seq_tms(SHIFT, r_type, 6'd0, r_len);
                      r_tdi   <= r_data[0];
                      r_data  <= r_data >> 1;
                    end
                  end
                  SHIFT: begin
                    r_state <= TAIL;
                    r_tms   <= 1'b1;
                  end
                  default: begin
                    // TAIL or RUNIDLE finished.
                    r_state     <= DONE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= (r_state == TAIL) ? w_aligned : '0;
                  end
                endcase
              end
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = !r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign tck       = r_tck;
  assign tms       = r_tms;
  assign tdi       = r_tdi;
  assign trst      = r_trst;

endmodule

// File: tb/tb_jtag_host.sv
// Scoreboard bench for jtag_host: the driver pushes the expected TCK/TMS/TDI trace and
// capture for each accepted command; a monitor pops and compares on every rsp_valid.
module tb_jtag_host;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned MAX_LEN = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_type = '0;
  logic [5:0]         cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;
  logic               tck, tms, tdi, trst, tdo;

  typedef struct {
    logic [31:0] rsp;
    int          n;
    logic [63:0] tms;
    logic [63:0] tdi;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          pass_n = 0;
  int          total_n = 0;
  int          rsp_n = 0;
  int          exp_rsp_n = 0;
  logic [31:0] last_rsp = '0;
  logic [63:0] cur_pat = '0;
  logic [6:0]  trace_n = '0;
  logic [63:0] tms_tr = '0;
  logic [63:0] tdi_tr = '0;

  // Device stand-in: the k-th rising TCK of a command sees pattern bit k on TDO.
  assign tdo = cur_pat[trace_n[5:0]];

  always #5 clk = ~clk;

  jtag_host #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .trst      (trst),
    .tdo       (tdo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total_n++;
    if (act === expv) pass_n++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
  endtask

  task automatic fail_bound(input string name);
    total_n++;
    $display("FAIL %s: got timeout, required DUT event within bound", name);
  endtask

  // Reference: the TCK-by-TCK TMS/TDI sequence a TAP walk needs, and the TDO bits
  // that land in the shift window.
  function automatic exp_t model(input logic [1:0] t, input logic [5:0] l,
                                 input logic [31:0] d, input logic [63:0] p);
    exp_t e;
    bit   tq[$];
    bit   dq[$];
    int   n;
    int   h;
    n = (l > 6'd32) ? 32 : int'(l);
    e.rsp = '0;
    e.tms = '0;
    e.tdi = '0;
    if (t == 2'd0) begin
      tq = '{1, 1, 1, 1, 1, 0};
      for (int i = 0; i < 6; i++) dq.push_back(1'b0);
    end else if (n != 0) begin
      if (t == 2'd3) begin
        for (int i = 0; i < n; i++) begin
          tq.push_back(1'b0);
          dq.push_back(1'b0);
        end
      end else begin
        if (t == 2'd2) tq = '{1, 0, 0};
        else           tq = '{1, 1, 0, 0};
        h = tq.size();
        for (int i = 0; i < h; i++) dq.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
          tq.push_back(i == n - 1);
          dq.push_back(d[i]);
          e.rsp[i] = p[h + i];
        end
        tq.push_back(1'b1);
        tq.push_back(1'b0);
        dq.push_back(1'b0);
        dq.push_back(1'b0);
      end
    end
    e.n = tq.size();
    for (int i = 0; i < e.n; i++) begin
      e.tms[i] = tq[i];
      e.tdi[i] = dq[i];
    end
    return e;
  endfunction

  always @(posedge tck) begin
    if (trace_n < 7'd64) begin
      tms_tr[trace_n[5:0]] = tms;
      tdi_tr[trace_n[5:0]] = tdi;
    end
    trace_n = trace_n + 7'd1;
  end

  always @(negedge clk) begin
    if (reset && rsp_valid) begin
      chk("busy_at_rsp", 64'({busy, cmd_ready}), 64'(2'b10));
      if (exp_q.size() == 0) begin
        total_n++;
        $display("FAIL unexpected_rsp: got rsp_valid with nothing outstanding, required none");
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(mon_e.rsp));
        chk("tck_count", 64'(trace_n), 64'(mon_e.n));
        chk("tms_trace", tms_tr, mon_e.tms);
        chk("tdi_trace", tdi_tr, mon_e.tdi);
      end
      rsp_n++;
      trace_n = '0;
      tms_tr  = '0;
      tdi_tr  = '0;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pins"}, 64'({tck, tms, tdi, trst}), 64'(4'b0101));
    chk({tag, "_handshake"}, 64'({cmd_ready, busy, rsp_valid}), 64'(3'b010));
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
  endtask

  task automatic run_init(input string tag);
    int n;
    bit trst_ok;
    trace_n = '0;
    tms_tr  = '0;
    tdi_tr  = '0;
    @(negedge clk);
    reset   = 1'b1;
    n       = 0;
    trst_ok = 1'b1;
    while (!cmd_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
      if (!cmd_ready && !trst) trst_ok = 1'b0;
    end
    if (!cmd_ready) begin
      fail_bound({tag, "_ready"});
    end else begin
      chk({tag, "_clks"}, 64'(n), 64'd24);
      chk({tag, "_tcks"}, 64'(trace_n), 64'd6);
      chk({tag, "_tms"}, tms_tr, 64'h1f);
      chk({tag, "_tdi"}, tdi_tr, 64'd0);
      chk({tag, "_trst_held"}, 64'(trst_ok), 64'd1);
      chk({tag, "_trst_low"}, 64'(trst), 64'd0);
    end
    trace_n = '0;
    tms_tr  = '0;
    tdi_tr  = '0;
  endtask

  // Presents a command (leaving cmd_valid high) and returns 1 time unit after acceptance.
  task automatic issue(input logic [1:0] t, input logic [5:0] l, input logic [31:0] d,
                       input logic [63:0] p);
    exp_t e;
    int   n;
    @(negedge clk);
    cmd_type  = t;
    cmd_len   = l;
    cmd_data  = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      fail_bound("accept");
      return;
    end
    cur_pat = p;
    e = model(t, l, d, p);
    last_rsp = e.rsp;
    exp_q.push_back(e);
    exp_rsp_n++;
    @(posedge clk);
    #1;
    chk("ready_drop", 64'(cmd_ready), 64'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !cmd_ready) begin
      fail_bound("complete");
      exp_q.delete();
    end
  endtask

  task automatic run_cmd(input logic [1:0] t, input logic [5:0] l, input logic [31:0] d,
                         input logic [63:0] p);
    issue(t, l, d, p);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n;
    logic [63:0] ones;
    ones = '1;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    run_init("init");

    // Directed cases.
    run_cmd(2'd2, 6'd32, 32'ha5a5_5a5a, {$urandom, $urandom});
    repeat (5) @(negedge clk);
    chk("rsp_hold", 64'(rsp_data), 64'(last_rsp));
    run_cmd(2'd1, 6'd4, 32'h5, ones);

    issue(2'd3, 6'd0, $urandom, {$urandom, $urandom});
    n = 0;
    while (!rsp_valid && n < 2) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle0_rsp_latency", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();

    run_cmd(2'd2, 6'd40, $urandom, {$urandom, $urandom});
    run_cmd(2'd0, 6'($urandom_range(0, 63)), $urandom, {$urandom, $urandom});
    run_cmd(2'd3, 6'd7, $urandom, {$urandom, $urandom});

    // Randomized commands.
    for (int k = 0; k < 40; k++) begin
      run_cmd(2'($urandom_range(0, 3)), 6'($urandom_range(0, 45)), $urandom,
              {$urandom, $urandom});
    end

    // Back-to-back with cmd_valid held high throughout.
    for (int k = 0; k < 10; k++) begin
      issue(2'($urandom_range(0, 3)), 6'($urandom_range(0, 40)), $urandom,
            {$urandom, $urandom});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();

    // Reset on the 10th shift TCK of a DR scan.
    issue(2'd2, 6'd32, $urandom, {$urandom, $urandom});
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (trace_n < 7'd13 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (trace_n != 7'd13) fail_bound("tenth_shift_tck");
    reset = 1'b0;
    #1;
    chk_reset_vals("midrst");
    exp_q.delete();
    exp_rsp_n--;
    repeat (4) @(negedge clk);
    run_init("reinit");
    run_cmd(2'd2, 6'd16, $urandom, {$urandom, $urandom});

    chk("rsp_count", 64'(rsp_n), 64'(exp_rsp_n));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, required completion within 900000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
